// File: rtl/mmu_refill_if.sv
// Memory read port plus MMU register write port used by the refill sequencer.
// Latency: n/a (wires only).
// Backpressure: memory paces reads with mem_ack; the MMU write port cannot stall.
interface mmu_refill_if #(
  parameter int RV = 16,
  parameter int PA = RV
);
  logic          mem_req;
  logic [PA-1:0] mem_addr;
  logic          mem_ack;
  logic [RV-1:0] mem_rdata;
  logic          mem_err;
  logic          mmu_reg_write;
  logic [RV-1:0] mmu_reg_data;

  // The refill sequencer drives the request and the MMU write.
  modport master (
    output mem_req, mem_addr, mmu_reg_write, mmu_reg_data,
    input  mem_ack, mem_rdata, mem_err
  );

  // The memory and MMU side answer the request and take the write.
  modport slave (
    input  mem_req, mem_addr, mmu_reg_write, mmu_reg_data,
    output mem_ack, mem_rdata, mem_err
  );
endinterface

// File: rtl/mmu_refill.sv
// Hardware MMU miss refill: reads the PTE from a table, then writes the MMU entry or traps.
// Latency: fault_req -> mem_req 1 cycle; mem_ack -> mmu_reg_write/done 1 cycle.
// Backpressure: waits on mem_ack up to TIMEOUT cycles; the core stalls while busy is high.
module mmu_refill #(
  parameter int RV        = 16,
  parameter int PA        = RV,
  parameter int VA        = RV,
  parameter int NMMU      = 8,
  parameter int VPN_W     = $clog2(NMMU),
  parameter int TIMEOUT   = 63,
  parameter int TIMEOUT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             walk_enable,
  input  logic             fault_req,
  input  logic [VPN_W-1:0] fault_vpn,
  input  logic             fault_ins,
  input  logic             fault_sup,
  input  logic [PA-1:0]    tbase_u,
  input  logic [PA-1:0]    tbase_s,
  input  logic             abort,
  mmu_refill_if.master     bus,
  output logic             busy,
  output logic             done,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [15:0]      refill_count
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WRITE} state_t;

  localparam logic [1:0] CAUSE_DISABLED = 2'd0;
  localparam logic [1:0] CAUSE_NOTPRES  = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
  localparam logic [1:0] CAUSE_BUSERR   = 2'd3;

  state_t               state;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic [PA-1:0]        base_sel;

  // Table base for the faulting bank; its low bits are replaced by {ins, vpn}.
  assign base_sel = fault_sup ? tbase_s : tbase_u;

  // The table base low bits and PTE bit0 are intentionally dropped.
  logic unused_ok;
  assign unused_ok = ^{tbase_u[VPN_W:0], tbase_s[VPN_W:0], bus.mem_rdata[0], (VA > 0)};

  // Refill sequencer: every output is registered and pulses default low each cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= S_IDLE;
      tmo_cnt           <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      trap              <= 1'b0;
      trap_cause        <= 2'd0;
      refill_count      <= 16'd0;
      bus.mem_req       <= 1'b0;
      bus.mem_addr      <= '0;
      bus.mmu_reg_write <= 1'b0;
      bus.mmu_reg_data  <= '0;
    end else begin
      done              <= 1'b0;
      trap              <= 1'b0;
      bus.mmu_reg_write <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fault_req) begin
            if (walk_enable) begin
              state        <= S_REQ;
              busy         <= 1'b1;
              bus.mem_req  <= 1'b1;
              bus.mem_addr <= {base_sel[PA-1:VPN_W+1], fault_ins, fault_vpn};
              tmo_cnt      <= TIMEOUT_W'(TIMEOUT);
            end else begin
              trap       <= 1'b1;
              trap_cause <= CAUSE_DISABLED;
            end
          end
        end
        S_REQ, S_WAIT: begin
          if (abort) begin
            // Cancel wins over any same-cycle ack, error or timeout.
            state       <= S_IDLE;
            busy        <= 1'b0;
            bus.mem_req <= 1'b0;
          end else if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            if (bus.mem_err) begin
              state      <= S_IDLE;
              busy       <= 1'b0;
              trap       <= 1'b1;
              trap_cause <= CAUSE_BUSERR;
            end else if (!bus.mem_rdata[1]) begin
              state      <= S_IDLE;
              busy       <= 1'b0;
              trap       <= 1'b1;
              trap_cause <= CAUSE_NOTPRES;
            end else begin
              // Entry-write format: keep PTE bits [RV-1:2], force valid and write bits.
              state             <= S_WRITE;
              bus.mmu_reg_write <= 1'b1;
              bus.mmu_reg_data  <= {bus.mem_rdata[RV-1:3], bus.mem_rdata[2], 2'b11};
              done              <= 1'b1;
              if (refill_count != 16'hFFFF) refill_count <= refill_count + 16'd1;
            end
          end else if (state == S_WAIT && TIMEOUT != 0 && tmo_cnt == TIMEOUT_W'(1)) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            bus.mem_req <= 1'b0;
            trap        <= 1'b1;
            trap_cause  <= CAUSE_TIMEOUT;
          end else begin
            state <= S_WAIT;
            if (state == S_WAIT) tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        S_WRITE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state       <= S_IDLE;
          busy        <= 1'b0;
          bus.mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_refill.sv
// Directed bench for mmu_refill with a per-cycle reference model and literal spot checks.
// Latency: n/a.
// Backpressure: the bench plays the memory and chooses when to return mem_ack.
module tb_mmu_refill;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        walk_enable = 1'b0;
  logic        fault_req = 1'b0;
  logic [2:0]  fault_vpn = 3'd0;
  logic        fault_ins = 1'b0;
  logic        fault_sup = 1'b0;
  logic [15:0] tbase_u = 16'h0;
  logic [15:0] tbase_s = 16'h0;
  logic        abort = 1'b0;
  logic        busy, done, trap;
  logic [1:0]  trap_cause;
  logic [15:0] refill_count;

  int checks = 0;
  int errors = 0;

  mmu_refill_if #(.RV(16), .PA(16)) bus ();

  mmu_refill #(.RV(16), .PA(16), .VA(16), .NMMU(8), .TIMEOUT(TMO), .TIMEOUT_W(6)) dut (
    .clk(clk), .reset(reset), .walk_enable(walk_enable), .fault_req(fault_req),
    .fault_vpn(fault_vpn), .fault_ins(fault_ins), .fault_sup(fault_sup),
    .tbase_u(tbase_u), .tbase_s(tbase_s), .abort(abort), .bus(bus),
    .busy(busy), .done(done), .trap(trap), .trap_cause(trap_cause),
    .refill_count(refill_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: a walk is "open" from acceptance until ack/abort/timeout;
  // mem_req may stay up for at most 1+TMO cycles; a good PTE yields one write cycle.
  logic        m_busy = 0, m_req = 0, m_write = 0, m_done = 0, m_trap = 0;
  logic        m_open = 0, m_wr = 0;
  logic [1:0]  m_cause = 0;
  logic [15:0] m_addr = 0, m_data = 0, m_count = 0;
  int          m_age = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_req = 0; m_write = 0; m_done = 0; m_trap = 0;
      m_open = 0; m_wr = 0; m_cause = 0; m_count = 0; m_age = 0;
    end else begin
      m_write = 0; m_done = 0; m_trap = 0;
      if (m_wr) begin
        m_wr = 0; m_busy = 0;
      end else if (m_open) begin
        if (abort) begin
          m_open = 0; m_busy = 0; m_req = 0;
        end else if (bus.mem_ack) begin
          m_open = 0; m_req = 0;
          if (bus.mem_err) begin
            m_busy = 0; m_trap = 1; m_cause = 3;
          end else if ((bus.mem_rdata & 16'h0002) == 0) begin
            m_busy = 0; m_trap = 1; m_cause = 1;
          end else begin
            m_wr = 1; m_write = 1; m_done = 1;
            m_data = bus.mem_rdata | 16'h0003;
            if (m_count != 16'hFFFF) m_count = m_count + 1;
          end
        end else if (TMO != 0 && m_age == TMO + 1) begin
          m_open = 0; m_busy = 0; m_req = 0; m_trap = 1; m_cause = 2;
        end else begin
          m_age++;
        end
      end else if (fault_req) begin
        if (walk_enable) begin
          m_open = 1; m_busy = 1; m_req = 1; m_age = 1;
          m_addr = ((fault_sup ? tbase_s : tbase_u) & 16'hFFF0) + 16'(fault_ins) * 16'd8 + 16'(fault_vpn);
        end else begin
          m_trap = 1; m_cause = 0;
        end
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    chk("busy", busy, m_busy);
    chk("mem_req", bus.mem_req, m_req);
    if (m_req) chk("mem_addr", bus.mem_addr, m_addr);
    chk("reg_write", bus.mmu_reg_write, m_write);
    if (m_write) chk("reg_data", bus.mmu_reg_data, m_data);
    chk("done", done, m_done);
    chk("trap", trap, m_trap);
    chk("trap_cause", trap_cause, m_cause);
    chk("refill_count", refill_count, m_count);
    chk("trap_and_done", trap & done, 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fault(input logic [2:0] vpn, input logic ins, input logic sup);
    fault_vpn = vpn; fault_ins = ins; fault_sup = sup; fault_req = 1'b1;
    tick();
    fault_req = 1'b0;
  endtask

  initial begin
    int n;
    bus.mem_ack = 1'b0; bus.mem_rdata = 16'h0; bus.mem_err = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_count", refill_count, 0);
    walk_enable = 1'b1; tbase_u = 16'h1200; tbase_s = 16'h3450;

    // Refill with ack in the third request cycle.
    fault(3'd5, 1'b1, 1'b0);
    tick(); tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hA006;
    chk("refill_addr", bus.mem_addr, 16'h120D);
    tick();
    bus.mem_ack = 1'b0;
    chk("refill_write", bus.mmu_reg_write, 1);
    chk("refill_data", bus.mmu_reg_data, 16'hA007);
    chk("refill_done", done, 1);
    tick();
    chk("refill_done_off", done, 0);
    chk("refill_busy_off", busy, 0);
    chk("refill_count1", refill_count, 1);

    // Not present.
    fault(3'd1, 1'b0, 1'b0);
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hA004;
    tick();
    bus.mem_ack = 1'b0;
    chk("np_trap", trap, 1);
    chk("np_cause", trap_cause, 1);
    chk("np_nowrite", bus.mmu_reg_write, 0);
    tick();

    // Bus error, zero-wait, supervisor bank.
    fault(3'd2, 1'b0, 1'b1);
    chk("be_addr", bus.mem_addr, 16'h3452);
    bus.mem_ack = 1'b1; bus.mem_err = 1'b1; bus.mem_rdata = 16'hA006;
    tick();
    bus.mem_ack = 1'b0; bus.mem_err = 1'b0;
    chk("be_trap", trap, 1);
    chk("be_cause", trap_cause, 3);
    tick();

    // Zero-wait refill latency.
    fault(3'd7, 1'b1, 1'b1);
    chk("zw_addr", bus.mem_addr, 16'h345F);
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h5432;
    tick();
    bus.mem_ack = 1'b0;
    chk("zw_write", bus.mmu_reg_write, 1);
    chk("zw_data", bus.mmu_reg_data, 16'h5433);
    chk("zw_busy_in_write", busy, 1);
    tick();
    chk("zw_busy_off", busy, 0);
    chk("zw_count2", refill_count, 2);

    // Timeout: request held for REQ + TMO wait cycles.
    fault(3'd3, 1'b0, 1'b0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.mem_req) break;
      n++;
      tick();
    end
    chk("tmo_req_cycles", n, 5);
    chk("tmo_trap", trap, 1);
    chk("tmo_cause", trap_cause, 2);
    // Late ack in idle is ignored.
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hA006;
    tick();
    bus.mem_ack = 1'b0;
    chk("late_nowrite", bus.mmu_reg_write, 0);
    chk("late_nodone", done, 0);
    tick();

    // Abort beats a same-cycle ack; fault while busy starts nothing.
    fault(3'd4, 1'b0, 1'b0);
    tick();
    fault_req = 1'b1;
    tick();
    fault_req = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hA006; abort = 1'b1;
    tick();
    bus.mem_ack = 1'b0; abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_nowrite", bus.mmu_reg_write, 0);
    chk("ab_nodone", done, 0);
    chk("ab_notrap", trap, 0);
    repeat (3) tick();
    chk("ab_no_second_walk", bus.mem_req, 0);
    chk("ab_count", refill_count, 2);

    // Reset in the middle of a wait.
    fault(3'd6, 1'b1, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_req", bus.mem_req, 0);
    chk("mrst_cause", trap_cause, 0);
    chk("mrst_count", refill_count, 0);
    tick();
    reset = 1'b0;

    // Clean walk after reset.
    fault(3'd5, 1'b1, 1'b0);
    chk("post_addr", bus.mem_addr, 16'h120D);
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hA006;
    tick();
    bus.mem_ack = 1'b0;
    chk("post_data", bus.mmu_reg_data, 16'hA007);
    tick();
    chk("post_count", refill_count, 1);

    // Walk disabled: trap cause 0 next cycle, no request.
    walk_enable = 1'b0;
    fault(3'd1, 1'b0, 1'b0);
    chk("dis_trap", trap, 1);
    chk("dis_cause", trap_cause, 0);
    chk("dis_req", bus.mem_req, 0);
    chk("dis_busy", busy, 0);
    tick();
    chk("dis_trap_off", trap, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
